// File: rtl/cpu_pkg.sv
// Shared constants and types for the register-file writeback path.
package cpu_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned SEL_W    = 4;
  localparam int unsigned DATA_W   = 32;

  // Identifies the last requester that won the write port.
  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_e;

  // One writeback payload: destination register and value.
  typedef struct packed {
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of writeback requests, issue/query scoreboard signals and the
// register-file write port.
interface regfile_wb_arbiter_if;
  import cpu_pkg::*;

  logic                alu_valid;
  logic [SEL_W-1:0]    alu_sel;
  logic [DATA_W-1:0]   alu_data;
  logic                alu_ready;

  logic                mem_valid;
  logic [SEL_W-1:0]    mem_sel;
  logic [DATA_W-1:0]   mem_data;
  logic                mem_ready;

  logic                issue_valid;
  logic [SEL_W-1:0]    issue_sel;
  logic                flush;

  logic [SEL_W-1:0]    query_sel1;
  logic [SEL_W-1:0]    query_sel2;
  logic                query_busy1;
  logic                query_busy2;
  logic [NUM_REGS-1:0] busy_mask;

  logic [SEL_W-1:0]    rf_write_sel;
  logic [DATA_W-1:0]   rf_write_data;
  logic                rf_write_enable;
  logic                wb_unexpected;

  // Pipeline side driving requests and queries.
  modport master (
    output alu_valid, alu_sel, alu_data,
    output mem_valid, mem_sel, mem_data,
    output issue_valid, issue_sel, flush,
    output query_sel1, query_sel2,
    input  alu_ready, mem_ready,
    input  query_busy1, query_busy2, busy_mask,
    input  rf_write_sel, rf_write_data, rf_write_enable, wb_unexpected
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_sel, alu_data,
    input  mem_valid, mem_sel, mem_data,
    input  issue_valid, issue_sel, flush,
    input  query_sel1, query_sel2,
    output alu_ready, mem_ready,
    output query_busy1, query_busy2, busy_mask,
    output rf_write_sel, rf_write_data, rf_write_enable, wb_unexpected
  );

endinterface

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Per-register busy scoreboard: set on issue, cleared on committed
// writeback, bulk-cleared on flush; flags writebacks to idle registers.
module reg_scoreboard
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [SEL_W-1:0]    wr_sel,
  input  logic                issue_valid,
  input  logic [SEL_W-1:0]    issue_sel,
  input  logic                flush,
  input  logic [SEL_W-1:0]    query_sel1,
  input  logic [SEL_W-1:0]    query_sel2,
  output logic                query_busy1,
  output logic                query_busy2,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                wb_unexpected
);

  logic [NUM_REGS-1:0] busy_d;

  // Next busy state: clear on commit, then set on issue so a newer producer wins.
  always_comb begin
    busy_d = busy_mask;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_en) busy_d[wr_sel] = 1'b0;
      if (issue_valid) busy_d[issue_sel] = 1'b1;
    end
  end

  // Scoreboard state and sticky unexpected-writeback flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_mask     <= '0;
      wb_unexpected <= 1'b0;
    end else begin
      busy_mask <= busy_d;
      if (wr_en && !busy_mask[wr_sel]) wb_unexpected <= 1'b1;
    end
  end

  assign query_busy1 = busy_mask[query_sel1];
  assign query_busy2 = busy_mask[query_sel2];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbitration of ALU and load writebacks onto the single
// register-file write port, plus the RAW-hazard busy scoreboard.
module regfile_wb_arbiter
  import cpu_pkg::*;
(
  input  logic clk,
  input  logic reset,
  regfile_wb_arbiter_if.slave bus
);

  wb_src_e rr_last;
  logic    grant_alu;
  logic    grant_mem;
  wb_req_t wr_q;
  logic    wr_en_q;

  // Grant: a lone requester wins; on conflict the one not granted last wins.
  always_comb begin
    grant_alu = 1'b0;
    grant_mem = 1'b0;
    if (bus.alu_valid && bus.mem_valid) begin
      if (rr_last == WB_MEM) grant_alu = 1'b1;
      else                   grant_mem = 1'b1;
    end else if (bus.alu_valid) begin
      grant_alu = 1'b1;
    end else if (bus.mem_valid) begin
      grant_mem = 1'b1;
    end
  end

  assign bus.alu_ready = grant_alu;
  assign bus.mem_ready = grant_mem;

  // Write-port register and round-robin pointer; sel/data hold when idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_last <= WB_MEM;
      wr_q    <= '0;
      wr_en_q <= 1'b0;
    end else if (grant_alu) begin
      rr_last   <= WB_ALU;
      wr_q.sel  <= bus.alu_sel;
      wr_q.data <= bus.alu_data;
      wr_en_q   <= 1'b1;
    end else if (grant_mem) begin
      rr_last   <= WB_MEM;
      wr_q.sel  <= bus.mem_sel;
      wr_q.data <= bus.mem_data;
      wr_en_q   <= 1'b1;
    end else begin
      wr_en_q <= 1'b0;
    end
  end

  assign bus.rf_write_sel    = wr_q.sel;
  assign bus.rf_write_data   = wr_q.data;
  assign bus.rf_write_enable = wr_en_q;

  reg_scoreboard u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en_q),
    .wr_sel        (wr_q.sel),
    .issue_valid   (bus.issue_valid),
    .issue_sel     (bus.issue_sel),
    .flush         (bus.flush),
    .query_sel1    (bus.query_sel1),
    .query_sel2    (bus.query_sel2),
    .query_busy1   (bus.query_busy1),
    .query_busy2   (bus.query_busy2),
    .busy_mask     (bus.busy_mask),
    .wb_unexpected (bus.wb_unexpected)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: reference model of grant/scoreboard, with
// expected write-port transactions queued at stimulus time.
module tb_regfile_wb_arbiter;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if bus();

  regfile_wb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int errors  = 0;

  wb_req_t exp_q[$];
  wb_req_t e;

  // Reference model state.
  logic                m_rr_mem;
  logic [NUM_REGS-1:0] m_busy;
  logic                m_unexp;
  logic                m_en;
  logic [SEL_W-1:0]    m_wsel;
  logic                m_galu, m_gmem;
  logic                obs_aready, obs_mready;

  // Requesters must keep a refused request stable until it is taken.
  logic    hold_a, hold_m;
  wb_req_t held_a, held_m;
  always @(posedge clk) begin
    if (!reset && hold_a)
      assert (bus.alu_valid && bus.alu_sel == held_a.sel && bus.alu_data == held_a.data)
        else $error("FAIL hold_alu: request changed before ready");
    if (!reset && hold_m)
      assert (bus.mem_valid && bus.mem_sel == held_m.sel && bus.mem_data == held_m.data)
        else $error("FAIL hold_mem: request changed before ready");
    hold_a      <= !reset && bus.alu_valid && !bus.alu_ready;
    hold_m      <= !reset && bus.mem_valid && !bus.mem_ready;
    held_a.sel  <= bus.alu_sel;
    held_a.data <= bus.alu_data;
    held_m.sel  <= bus.mem_sel;
    held_m.data <= bus.mem_data;
  end

  task automatic model_init();
    m_rr_mem = 1'b1;
    m_busy   = '0;
    m_unexp  = 1'b0;
    m_en     = 1'b0;
    m_wsel   = '0;
    exp_q.delete();
  endtask

  task automatic zero_inputs();
    bus.alu_valid = 1'b0; bus.alu_sel = '0; bus.alu_data = '0;
    bus.mem_valid = 1'b0; bus.mem_sel = '0; bus.mem_data = '0;
    bus.issue_valid = 1'b0; bus.issue_sel = '0; bus.flush = 1'b0;
    bus.query_sel1 = '0; bus.query_sel2 = '0;
  endtask

  task automatic do_reset();
    zero_inputs();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_init();
  endtask

  // Drive one cycle of stimulus, update the model, push expected writes,
  // and return #1 after the rising edge.
  task automatic cycle(input logic av, input logic [SEL_W-1:0] as, input logic [DATA_W-1:0] ad,
                       input logic mv, input logic [SEL_W-1:0] ms, input logic [DATA_W-1:0] md,
                       input logic iv, input logic [SEL_W-1:0] isel, input logic fl);
    logic [NUM_REGS-1:0] nb;
    wb_req_t r;
    @(negedge clk);
    bus.alu_valid = av; bus.alu_sel = as; bus.alu_data = ad;
    bus.mem_valid = mv; bus.mem_sel = ms; bus.mem_data = md;
    bus.issue_valid = iv; bus.issue_sel = isel; bus.flush = fl;
    #1;
    obs_aready = bus.alu_ready;
    obs_mready = bus.mem_ready;
    m_galu = av && (!mv || m_rr_mem);
    m_gmem = mv && !m_galu;
    nb = m_busy;
    if (fl) nb = '0;
    else begin
      if (m_en) nb[m_wsel] = 1'b0;
      if (iv) nb[isel] = 1'b1;
    end
    if (m_en && !m_busy[m_wsel]) m_unexp = 1'b1;
    m_busy = nb;
    if (m_galu) begin
      r.sel = as; r.data = ad; exp_q.push_back(r);
      m_en = 1'b1; m_wsel = as; m_rr_mem = 1'b0;
    end else if (m_gmem) begin
      r.sel = ms; r.data = md; exp_q.push_back(r);
      m_en = 1'b1; m_wsel = ms; m_rr_mem = 1'b1;
    end else begin
      m_en = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cycle(0, '0, '0, 0, '0, '0, 0, '0, 0);
  endtask

  task automatic issue(input logic [SEL_W-1:0] s);
    cycle(0, '0, '0, 0, '0, '0, 1, s, 0);
  endtask

  task automatic test_reset();
    zero_inputs();
    reset = 1'b1;
    #3;
    vectors++;
    if (bus.rf_write_enable !== 1'b0 || bus.rf_write_sel !== '0 || bus.rf_write_data !== '0) begin
      errors++;
      $display("FAIL reset_port: en=%b sel=%0h data=%0h want 0/0/0", bus.rf_write_enable, bus.rf_write_sel, bus.rf_write_data);
    end
    vectors++;
    if (bus.busy_mask !== '0 || bus.wb_unexpected !== 1'b0) begin
      errors++;
      $display("FAIL reset_sb: busy=%0h unexp=%b want 0/0", bus.busy_mask, bus.wb_unexpected);
    end
    vectors++;
    if (bus.alu_ready !== 1'b0 || bus.mem_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: alu=%b mem=%b want 0/0", bus.alu_ready, bus.mem_ready);
    end
    do_reset();
  endtask

  task automatic test_single_alu();
    issue(4'd3);
    vectors++;
    if (bus.busy_mask !== 16'h0008) begin
      errors++; $display("FAIL alu_issue_busy: got %0h want 0008", bus.busy_mask);
    end
    cycle(1, 4'd3, 32'hDEADBEEF, 0, '0, '0, 0, '0, 0);
    vectors++;
    if (obs_aready !== 1'b1 || obs_mready !== 1'b0) begin
      errors++; $display("FAIL alu_ready: alu=%b mem=%b want 1/0", obs_aready, obs_mready);
    end
    e = exp_q.pop_front();
    vectors++;
    if (bus.rf_write_enable !== 1'b1 || bus.rf_write_sel !== e.sel || bus.rf_write_data !== e.data) begin
      errors++;
      $display("FAIL alu_port: en=%b sel=%0h data=%0h want 1/%0h/%0h", bus.rf_write_enable, bus.rf_write_sel, bus.rf_write_data, e.sel, e.data);
    end
    vectors++;
    if (bus.busy_mask[3] !== 1'b1) begin
      errors++; $display("FAIL alu_busy_n1: got %b want 1", bus.busy_mask[3]);
    end
    idle();
    vectors++;
    if (bus.busy_mask[3] !== 1'b0 || bus.rf_write_enable !== 1'b0) begin
      errors++; $display("FAIL alu_clear: busy3=%b en=%b want 0/0", bus.busy_mask[3], bus.rf_write_enable);
    end
    vectors++;
    if (bus.rf_write_sel !== 4'd3 || bus.rf_write_data !== 32'hDEADBEEF || bus.wb_unexpected !== 1'b0) begin
      errors++; $display("FAIL alu_hold: sel=%0h data=%0h unexp=%b want 3/deadbeef/0", bus.rf_write_sel, bus.rf_write_data, bus.wb_unexpected);
    end
  endtask

  task automatic test_back_to_back();
    logic [SEL_W-1:0] order [8];
    int ai, mi;
    order = '{4'd1, 4'd5, 4'd2, 4'd6, 4'd3, 4'd7, 4'd4, 4'd8};
    ai = 0; mi = 0;
    do_reset();
    for (int r = 1; r <= 8; r++) issue(SEL_W'(r));
    for (int c = 0; c < 8; c++) begin
      cycle(ai < 4, SEL_W'(ai + 1), DATA_W'(32'hA000_0000 + ai),
            mi < 4, SEL_W'(mi + 5), DATA_W'(32'hB000_0000 + mi), 0, '0, 0);
      vectors++;
      if (obs_aready !== m_galu || obs_mready !== m_gmem) begin
        errors++;
        $display("FAIL b2b_ready[%0d]: alu=%b mem=%b want %b/%b", c, obs_aready, obs_mready, m_galu, m_gmem);
      end
      if (m_galu) ai++;
      if (m_gmem) mi++;
      e = exp_q.pop_front();
      vectors++;
      if (bus.rf_write_enable !== 1'b1 || bus.rf_write_sel !== order[c] || bus.rf_write_sel !== e.sel || bus.rf_write_data !== e.data) begin
        errors++;
        $display("FAIL b2b_port[%0d]: en=%b sel=%0h data=%0h want 1/%0h/%0h", c, bus.rf_write_enable, bus.rf_write_sel, bus.rf_write_data, order[c], e.data);
      end
    end
    idle();
    vectors++;
    if (bus.busy_mask !== 16'h0000 || bus.wb_unexpected !== 1'b0) begin
      errors++; $display("FAIL b2b_sb: busy=%0h unexp=%b want 0/0", bus.busy_mask, bus.wb_unexpected);
    end
  endtask

  task automatic test_hazard();
    bus.query_sel1 = 4'd7;
    bus.query_sel2 = 4'd3;
    issue(4'd7);
    vectors++;
    if (bus.query_busy1 !== 1'b1 || bus.query_busy2 !== 1'b0) begin
      errors++; $display("FAIL haz_issue: q1=%b q2=%b want 1/0", bus.query_busy1, bus.query_busy2);
    end
    cycle(0, '0, '0, 1, 4'd7, 32'h0000_0777, 0, '0, 0);
    e = exp_q.pop_front();
    vectors++;
    if (obs_mready !== 1'b1 || bus.rf_write_enable !== 1'b1 || bus.rf_write_sel !== e.sel || bus.rf_write_data !== e.data) begin
      errors++;
      $display("FAIL haz_port: ready=%b en=%b sel=%0h data=%0h want 1/1/%0h/%0h", obs_mready, bus.rf_write_enable, bus.rf_write_sel, bus.rf_write_data, e.sel, e.data);
    end
    vectors++;
    if (bus.query_busy1 !== 1'b1) begin
      errors++; $display("FAIL haz_n1: q1=%b want 1", bus.query_busy1);
    end
    idle();
    vectors++;
    if (bus.query_busy1 !== 1'b0) begin
      errors++; $display("FAIL haz_n2: q1=%b want 0", bus.query_busy1);
    end
    bus.query_sel1 = '0;
    bus.query_sel2 = '0;
  endtask

  task automatic test_same_edge();
    issue(4'd9);
    cycle(1, 4'd9, 32'h0000_0999, 0, '0, '0, 0, '0, 0);
    e = exp_q.pop_front();
    vectors++;
    if (bus.rf_write_enable !== 1'b1 || bus.rf_write_sel !== e.sel || bus.rf_write_data !== e.data) begin
      errors++;
      $display("FAIL same_port: en=%b sel=%0h data=%0h want 1/%0h/%0h", bus.rf_write_enable, bus.rf_write_sel, bus.rf_write_data, e.sel, e.data);
    end
    issue(4'd9);
    vectors++;
    if (bus.busy_mask[9] !== 1'b1 || bus.wb_unexpected !== 1'b0 || bus.busy_mask !== m_busy) begin
      errors++; $display("FAIL same_edge: busy=%0h unexp=%b want %0h/0", bus.busy_mask, bus.wb_unexpected, m_busy);
    end
  endtask

  task automatic test_unexpected_flush();
    do_reset();
    cycle(0, '0, '0, 1, 4'd2, 32'h0000_0222, 0, '0, 0);
    e = exp_q.pop_front();
    vectors++;
    if (bus.rf_write_enable !== 1'b1 || bus.rf_write_sel !== e.sel || bus.wb_unexpected !== 1'b0) begin
      errors++; $display("FAIL unexp_pre: en=%b sel=%0h unexp=%b want 1/%0h/0", bus.rf_write_enable, bus.rf_write_sel, bus.wb_unexpected, e.sel);
    end
    idle();
    vectors++;
    if (bus.wb_unexpected !== 1'b1) begin
      errors++; $display("FAIL unexp_set: got %b want 1", bus.wb_unexpected);
    end
    for (int r = 4; r <= 7; r++) issue(SEL_W'(r));
    vectors++;
    if (bus.busy_mask !== 16'h00F0 || bus.wb_unexpected !== 1'b1) begin
      errors++; $display("FAIL unexp_sticky: busy=%0h unexp=%b want 00f0/1", bus.busy_mask, bus.wb_unexpected);
    end
    cycle(0, '0, '0, 1, 4'd5, 32'h0000_0555, 0, '0, 0);
    e = exp_q.pop_front();
    cycle(0, '0, '0, 0, '0, '0, 1, 4'd0, 1);
    vectors++;
    if (bus.busy_mask !== 16'h0000 || bus.busy_mask !== m_busy || bus.rf_write_enable !== 1'b0) begin
      errors++; $display("FAIL flush: busy=%0h en=%b want 0000/0", bus.busy_mask, bus.rf_write_enable);
    end
    vectors++;
    if (bus.rf_write_sel !== e.sel || bus.rf_write_data !== e.data || bus.wb_unexpected !== m_unexp) begin
      errors++; $display("FAIL flush_port: sel=%0h data=%0h unexp=%b want %0h/%0h/%b", bus.rf_write_sel, bus.rf_write_data, bus.wb_unexpected, e.sel, e.data, m_unexp);
    end
  endtask

  task automatic test_async_reset();
    issue(4'd1);
    cycle(1, 4'd1, 32'h0000_0111, 0, '0, '0, 0, '0, 0);
    e = exp_q.pop_front();
    vectors++;
    if (bus.rf_write_enable !== 1'b1 || bus.busy_mask !== 16'h0002 || bus.wb_unexpected !== 1'b1) begin
      errors++; $display("FAIL arst_pre: en=%b busy=%0h unexp=%b want 1/0002/1", bus.rf_write_enable, bus.busy_mask, bus.wb_unexpected);
    end
    #2;
    reset = 1'b1;
    #1;
    vectors++;
    if (bus.rf_write_enable !== 1'b0 || bus.busy_mask !== '0 || bus.wb_unexpected !== 1'b0 || bus.rf_write_sel !== '0 || bus.rf_write_data !== '0) begin
      errors++;
      $display("FAIL arst: en=%b busy=%0h unexp=%b sel=%0h data=%0h want all 0", bus.rf_write_enable, bus.busy_mask, bus.wb_unexpected, bus.rf_write_sel, bus.rf_write_data);
    end
    do_reset();
    cycle(1, 4'd2, 32'h0000_0002, 1, 4'd3, 32'h0000_0003, 0, '0, 0);
    vectors++;
    if (obs_aready !== 1'b1 || obs_mready !== 1'b0) begin
      errors++; $display("FAIL arst_rr: alu=%b mem=%b want 1/0", obs_aready, obs_mready);
    end
    e = exp_q.pop_front();
    cycle(0, '0, '0, 1, 4'd3, 32'h0000_0003, 0, '0, 0);
    e = exp_q.pop_front();
    vectors++;
    if (bus.rf_write_sel !== 4'd3 || bus.rf_write_data !== e.data) begin
      errors++; $display("FAIL arst_mem: sel=%0h data=%0h want 3/%0h", bus.rf_write_sel, bus.rf_write_data, e.data);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_back_to_back();
    test_hazard();
    test_same_edge();
    test_unexpected_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
